// File: rtl/instruction_fetch.sv
// Instruction fetch stage: samples the PC, performs a req/ack read of instruction
// memory and presents the fetched word to the decoder over a valid/ready handshake.
module instruction_fetch #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_inc,
   input  logic              flush,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] ir_out,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic              discard_q,   discard_d;
   logic              imem_req_q,  imem_req_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic              pc_inc_q,    pc_inc_d;
   logic              ir_valid_q,  ir_valid_d;
   logic [DATA_W-1:0] ir_out_q,    ir_out_d;
   logic [ADDR_W-1:0] ir_pc_q,     ir_pc_d;

   // State and output registers; async reset also drops imem_req immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= FETCH;
         discard_q   <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= '0;
         pc_inc_q    <= 1'b0;
         ir_valid_q  <= 1'b0;
         ir_out_q    <= '0;
         ir_pc_q     <= '0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         pc_inc_q    <= pc_inc_d;
         ir_valid_q  <= ir_valid_d;
         ir_out_q    <= ir_out_d;
         ir_pc_q     <= ir_pc_d;
      end
   end

   // Next-state and registered-output logic; pc_inc defaults low so it is a single-cycle pulse.
   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      imem_req_d  = imem_req_q;
      imem_addr_d = imem_addr_q;
      pc_inc_d    = 1'b0;
      ir_valid_d  = ir_valid_q;
      ir_out_d    = ir_out_q;
      ir_pc_d     = ir_pc_q;

      case (state_q)
         FETCH: begin
            if (!flush) begin
               imem_addr_d = pc_in;
               imem_req_d  = 1'b1;
               state_d     = WAIT;
            end else begin
               state_d = FETCH;
            end
         end
         WAIT: begin
            // The request stays up until ack; a flush only marks the word as stale.
            if (imem_ack) begin
               imem_req_d = 1'b0;
               if (discard_q || flush) begin
                  discard_d = 1'b0;
                  state_d   = FETCH;
               end else begin
                  ir_out_d   = imem_rdata;
                  ir_pc_d    = imem_addr_q;
                  ir_valid_d = 1'b1;
                  pc_inc_d   = 1'b1;
                  state_d    = HOLD;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end else begin
               discard_d = discard_q;
            end
         end
         HOLD: begin
            if (flush) begin
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end else if (ir_valid_q && ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d    = FETCH;
            discard_d  = 1'b0;
            imem_req_d = 1'b0;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   assign pc_inc    = pc_inc_q;
   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign ir_valid  = ir_valid_q;
   assign ir_out    = ir_out_q;
   assign ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: PC and memory models, a scoreboard of
// expected {ir_pc, ir_out} pairs, a table of fetch scenarios and flush/reset sequences.
module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic [15:0] pc_in;
   logic        pc_inc;
   logic        flush;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] ir_out;
   logic [15:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;

   logic [15:0] load_val;
   int          mem_delay;
   int          wcnt;
   int          inc_cnt;
   int          n_cmp;
   int          n_fail;
   logic [31:0] sb_q[$];
   logic        prev_v;
   logic        prev_inc;

   typedef struct {
      int delay;
      int stall;
      int exp_lat;
   } vec_t;
   vec_t tbl[7];

   instruction_fetch #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .pc_inc     (pc_inc),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir_out     (ir_out),
      .ir_pc      (ir_pc),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Program counter model: load (driven together with flush) beats increment.
   always @(posedge clk or negedge reset) begin
      if (!reset)      pc_in <= 16'h0000;
      else if (flush)  pc_in <= load_val;
      else if (pc_inc) pc_in <= pc_in + 16'h0001;
   end

   // Memory model: ack after mem_delay extra cycles, data = 16'h1000 + address.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 16'h0000;
      wcnt       = 0;
      forever begin
         @(negedge clk);
         if (!imem_req) begin
            imem_ack = 1'b0;
            wcnt     = 0;
         end else if (wcnt >= mem_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'h1000 + imem_addr;
         end else begin
            imem_ack = 1'b0;
            wcnt     = wcnt + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expectation per ir_valid rise, counts pc_inc pulses.
   initial begin
      logic [31:0] item;
      prev_v   = 1'b0;
      prev_inc = 1'b0;
      inc_cnt  = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (ir_valid && !prev_v) begin
               if (sb_q.size() == 0) begin
                  check("sb_underflow", 32'd1, 32'd0);
               end else begin
                  item = sb_q.pop_front();
                  check("ir_pc", {16'h0000, ir_pc}, {16'h0000, item[31:16]});
                  check("ir_out", {16'h0000, ir_out}, {16'h0000, item[15:0]});
               end
            end
            if (pc_inc) begin
               check("pc_inc_single_cycle", {31'd0, prev_inc}, 32'd0);
               inc_cnt = inc_cnt + 1;
            end
         end
         prev_v   = ir_valid;
         prev_inc = pc_inc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete fetch starting in FETCH; returns one cycle after the decoder accepts.
   task automatic do_fetch(input int d, input int s, input logic [15:0] a, input int exp_lat);
      int          n;
      int          c0;
      logic [15:0] exp_d;
      exp_d     = 16'h1000 + a;
      mem_delay = d;
      ir_ready  = (s == 0);
      sb_q.push_back({a, exp_d});
      c0 = inc_cnt;
      n  = 0;
      do begin
         tick();
         n = n + 1;
         if (imem_req) check("imem_addr_held", {16'h0000, imem_addr}, {16'h0000, a});
      end while (!ir_valid && n < 40);
      check("valid_latency", n, exp_lat);
      check("req_dropped_on_ack", {31'd0, imem_req}, 32'd0);
      for (int k = 0; k < s; k++) begin
         tick();
         check("hold_valid", {31'd0, ir_valid}, 32'd1);
         check("hold_no_req", {31'd0, imem_req}, 32'd0);
         check("hold_ir_out", {16'h0000, ir_out}, {16'h0000, exp_d});
      end
      ir_ready = 1'b1;
      tick();
      check("valid_cleared", {31'd0, ir_valid}, 32'd0);
      check("pc_inc_count", inc_cnt - c0, 32'd1);
   endtask

   initial begin
      int          c0;
      int          n;
      logic [15:0] exp_pc;
      n_cmp     = 0;
      n_fail    = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      ir_ready  = 1'b1;
      load_val  = 16'h0000;
      mem_delay = 0;

      tbl[0] = '{0, 0, 2};
      tbl[1] = '{0, 0, 2};
      tbl[2] = '{0, 0, 2};
      tbl[3] = '{3, 0, 5};
      tbl[4] = '{0, 4, 2};
      tbl[5] = '{1, 0, 3};
      tbl[6] = '{2, 2, 4};

      tick();
      tick();
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_imem_addr", {16'h0000, imem_addr}, 32'd0);
      check("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
      check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      check("rst_ir_out", {16'h0000, ir_out}, 32'd0);
      check("rst_ir_pc", {16'h0000, ir_pc}, 32'd0);
      reset = 1'b1;

      exp_pc = 16'h0000;
      for (int i = 0; i < 7; i++) begin
         do_fetch(tbl[i].delay, tbl[i].stall, exp_pc, tbl[i].exp_lat);
         exp_pc = exp_pc + 16'h0001;
      end

      // Flush while in FETCH: no request, next fetch uses the loaded PC.
      flush    = 1'b1;
      load_val = 16'h0040;
      tick();
      flush = 1'b0;
      check("flush_fetch_no_req", {31'd0, imem_req}, 32'd0);
      do_fetch(0, 0, 16'h0040, 2);

      // Flush while the request is pending; ack arrives two cycles later.
      mem_delay = 2;
      ir_ready  = 1'b1;
      tick();
      check("wait_req_up", {31'd0, imem_req}, 32'd1);
      c0       = inc_cnt;
      flush    = 1'b1;
      load_val = 16'hABCD;
      tick();
      flush = 1'b0;
      n     = 0;
      while (imem_req && n < 20) begin
         check("flush_wait_no_valid", {31'd0, ir_valid}, 32'd0);
         check("flush_wait_addr_held", {16'h0000, imem_addr}, 32'h0000_0041);
         tick();
         n = n + 1;
      end
      check("flush_wait_req_dropped", {31'd0, imem_req}, 32'd0);
      check("flush_wait_no_valid_end", {31'd0, ir_valid}, 32'd0);
      check("flush_wait_no_pc_inc", inc_cnt - c0, 32'd0);
      do_fetch(0, 0, 16'hABCD, 2);

      // Flush in HOLD together with ir_ready: loaded address wins over increment.
      mem_delay = 0;
      ir_ready  = 1'b1;
      sb_q.push_back({16'hABCE, 16'hBBCE});
      tick();
      tick();
      check("hold_presented", {31'd0, ir_valid}, 32'd1);
      flush    = 1'b1;
      load_val = 16'h0200;
      tick();
      flush = 1'b0;
      check("flush_hold_valid_low", {31'd0, ir_valid}, 32'd0);
      check("flush_hold_no_req", {31'd0, imem_req}, 32'd0);
      do_fetch(0, 0, 16'h0200, 2);

      // Asynchronous reset in the middle of WAIT.
      mem_delay = 5;
      tick();
      check("pre_reset_req", {31'd0, imem_req}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_req", {31'd0, imem_req}, 32'd0);
      check("async_rst_valid", {31'd0, ir_valid}, 32'd0);
      check("async_rst_addr", {16'h0000, imem_addr}, 32'd0);
      tick();
      reset = 1'b1;
      do_fetch(0, 0, 16'h0000, 2);
      do_fetch(1, 1, 16'h0001, 3);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage sitting directly downstream of the 16-bit program counter. It samples the PC value, runs a req/ack read against instruction memory, and latches the returned word into the instruction register. It presents the instruction to the decoder with a valid/ready handshake and pulses the PC's increment input once per accepted fetch. A flush input discards in-flight or held instructions when the PC is reloaded for a branch or jump.

## Interface
- ADDR_W, 16, width of PC and instruction-memory address
- DATA_W, 16, instruction word width

- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- pc_in  input  ADDR_W  current PC value; connects to the program counter's out
- pc_inc  output  1  one-cycle increment pulse; connects to the program counter's inc
- flush  input  1  synchronous; asserted in the same cycle the PC's load is asserted
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  read address; stable while imem_req=1
- imem_ack  input  1  memory has valid imem_rdata this cycle
- imem_rdata  input  DATA_W  instruction word
- ir_out  output  DATA_W  instruction register
- ir_pc  output  ADDR_W  address the instruction in ir_out was fetched from
- ir_valid  output  1  ir_out/ir_pc valid for the decoder
- ir_ready  input  1  decoder accepts the instruction this cycle

## Operation
- All outputs are registered. There are 3 states: FETCH, WAIT, HOLD, plus a 1-bit discard flag.
- Reset (reset=0, asynchronous):
  - state=FETCH, discard=0.
  - imem_req=0, imem_addr=0, pc_inc=0, ir_valid=0, ir_out=0, ir_pc=0.
  - imem_req must drop immediately, without waiting for a clock edge.
- FETCH:
  - flush=0: imem_addr<=pc_in, imem_req<=1, go to WAIT.
  - flush=1: no request is issued; remain in FETCH.
- WAIT: imem_req and imem_addr are held until imem_ack is sampled high.
  - On ack with discard=0 and flush=0: ir_out<=imem_rdata, ir_pc<=imem_addr, ir_valid<=1, pc_inc<=1, imem_req<=0, go to HOLD.
  - On ack with discard=1 or flush=1: data is dropped, no pc_inc, imem_req<=0, discard<=0, go to FETCH.
  - flush=1 without ack: discard<=1. The request is never withdrawn mid-handshake.
- HOLD:
  - pc_inc returns to 0 after exactly one cycle.
  - ir_valid=1 and ir_ready=1: ir_valid<=0, go to FETCH.
  - flush=1: ir_valid<=0, go to FETCH. Flush takes priority over ready; the instruction is not consumed.
  - Otherwise ir_out, ir_pc and ir_valid hold stable.
- imem_ack is ignored outside WAIT.
- If flush coincides with the pc_inc pulse, the program counter's load has priority over inc. The block takes no special action.

## Timing
- Zero-wait memory (ack in the first WAIT cycle) with ir_ready tied to 1: one instruction every 3 cycles (FETCH, WAIT, HOLD).
- Fetch latency: ir_valid rises 2 edges after FETCH is entered, plus N edges for N extra wait cycles.
- pc_inc is high in the first HOLD cycle. The PC updates on the following edge, and the next FETCH samples pc_in one edge after that, so the next fetch always sees the incremented PC.
- After flush, the next FETCH samples the reloaded PC: at most 1 cycle later from HOLD or FETCH, or at ack+1 from WAIT.
- ir_out and ir_pc change only on the edge that raises ir_valid.

## Test plan
- Sequential fetch: reset, PC starts at 0, memory returns 16'h1000+addr with ack in the first WAIT cycle, ir_ready=1.
  - Expect ir_valid pulses every 3 cycles with ir_out=1000,1001,1002 and ir_pc=0,1,2.
  - Expect exactly one pc_inc per instruction.
- Memory wait states: ack delayed 3 cycles.
  - Expect imem_req and imem_addr held constant throughout.
  - Expect ir_valid 5 edges after FETCH.
- Decoder backpressure: ir_ready=0 for 4 cycles in HOLD.
  - Expect ir_out to hold its value, no new imem_req, and pc_inc pulsed only once.
  - On ready=1, expect the next fetch from addr+1.
- Flush in WAIT: assert flush plus PC load 16'hABCD while req is pending, ack 2 cycles later.
  - Expect no ir_valid and no pc_inc for the stale word.
  - Expect the next imem_addr to be ABCD.
- Flush in HOLD with ir_ready=1 in the same cycle: expect the instruction to be dropped and the next fetch from the loaded address.
- Reset mid-WAIT: drive reset=0 between edges.
  - Expect imem_req=0 and ir_valid=0 immediately.
  - After release, expect fetching to restart in FETCH with correct behaviour.
